rotary_quad_decoder: RTL



---
 rtl/rotary_quad_decoder_if.sv | 10 +
 rtl/rotary_quad_decoder.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/rotary_quad_decoder_if.sv
// Encoder-side bundle: raw quadrature pins in, detent/glitch pulses out.
interface rotary_quad_decoder_if;
    logic [1:0] rotary;
    logic       rotary_left;
    logic       rotary_right;
    logic       rotary_glitch;

    modport master (output rotary, input rotary_left, rotary_right, rotary_glitch);
    modport slave  (input rotary, output rotary_left, rotary_right, rotary_glitch);
endinterface

// File: rtl/rotary_quad_decoder.sv
// Rotary encoder front end: 2-flop sync + per-bit debounce, then a gray-code FSM
// that emits one registered pulse per completed detent step.
module rotary_debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_WIDTH       = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic i_pin,
    output logic o_filt
);
    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic [1:0]           r_sync;
    logic                 r_filt;
    logic [CNT_WIDTH-1:0] r_cnt;

    // Counter only advances while the synced pin disagrees with the filtered value,
    // so any bounce back restarts the qualification window.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync <= 2'b11;
            r_filt <= 1'b1;
            r_cnt  <= '0;
        end else begin
            r_sync <= {r_sync[0], i_pin};
            if (r_sync[1] != r_filt) begin
                if (r_cnt == LAST) begin
                    r_filt <= r_sync[1];
                    r_cnt  <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_WIDTH'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_filt = r_filt;
endmodule

module rotary_quad_decoder #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    rotary_quad_decoder_if.slave  bus
);
    typedef enum logic [2:0] {
        DETENT, R1, R2, R3, L1, L2, L3, RESYNC
    } state_t;

    logic [1:0] w_q;
    state_t     r_state, w_next;
    logic       w_left, w_right, w_glitch;
    logic       r_left, r_right, r_glitch;

    for (genvar b = 0; b < 2; b++) begin : g_bit
        rotary_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_WIDTH       (CNT_WIDTH)
        ) u_db (
            .clock  (clock),
            .reset  (reset),
            .i_pin  (bus.rotary[b]),
            .o_filt (w_q[b])
        );
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= DETENT;
            r_left   <= 1'b0;
            r_right  <= 1'b0;
            r_glitch <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_left   <= w_left;
            r_right  <= w_right;
            r_glitch <= w_glitch;
        end
    end

    // w_q = {B, A}; CW walks 11->10->00->01->11, CCW the reverse.
    always_comb begin
        w_next  = r_state;
        w_left  = 1'b0;
        w_right = 1'b0;
        unique case (r_state)
            DETENT: case (w_q)
                2'b10: w_next = R1;
                2'b01: w_next = L1;
                2'b00: w_next = RESYNC;
                default: ;
            endcase
            R1: case (w_q)
                2'b00: w_next = R2;
                2'b11: w_next = DETENT;
                2'b01: w_next = RESYNC;
                default: ;
            endcase
            R2: case (w_q)
                2'b01: w_next = R3;
                2'b10: w_next = R1;
                2'b11: w_next = RESYNC;
                default: ;
            endcase
            R3: case (w_q)
                2'b11: begin w_next = DETENT; w_right = 1'b1; end
                2'b00: w_next = R2;
                2'b10: w_next = RESYNC;
                default: ;
            endcase
            L1: case (w_q)
                2'b00: w_next = L2;
                2'b11: w_next = DETENT;
                2'b10: w_next = RESYNC;
                default: ;
            endcase
            L2: case (w_q)
                2'b10: w_next = L3;
                2'b01: w_next = L1;
                2'b11: w_next = RESYNC;
                default: ;
            endcase
            L3: case (w_q)
                2'b11: begin w_next = DETENT; w_left = 1'b1; end
                2'b00: w_next = L2;
                2'b01: w_next = RESYNC;
                default: ;
            endcase
            RESYNC: if (w_q == 2'b11) w_next = DETENT;
            default: w_next = DETENT;
        endcase
        w_glitch = (w_next == RESYNC) && (r_state != RESYNC);
    end

    assign bus.rotary_left   = r_left;
    assign bus.rotary_right  = r_right;
    assign bus.rotary_glitch = r_glitch;
endmodule
